adc_dac_sampler: RTL and testbench

//  Multi-channel sample engine between the XADC wrapper and the serial DAC encoder (dac_set_ad5626).
//  - Generates the conversion strobe.
//  - Tags and processes each ADC result per channel (pass-through, moving average, hold, invert).
//  - Schedules DAC writes through the encoder's set/busy handshake.

---
 rtl/adc_dac_pkg.sv | 17 +
 rtl/adc_dac_sampler_chan_avg.sv | 60 ++++++
 rtl/adc_dac_sampler.sv | 223 ++++++++++++++++++++++
 tb/tb_adc_dac_sampler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_dac_pkg.sv
// Shared definitions for the ADC-to-DAC sample engine.
//   MODE_*   : per-sample processing selected on the adc_valid cycle
//   state_e  : DAC write scheduler states
package adc_dac_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_AVG  = 2'd1;
    localparam logic [1:0] MODE_HOLD = 2'd2;
    localparam logic [1:0] MODE_INV  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_HI = 2'd1,
        S_WAIT_LO = 2'd2
    } state_e;

endpackage

// File: rtl/adc_dac_sampler_chan_avg.sv
// Per-channel moving-average state: ring of the last 2**AVG_LOG2 raw
// samples, their running sum and the ring write pointer.
//   clk, rst : clock, synchronous active-high reset
//   en       : accept din into the ring this cycle
//   din      : raw ADC sample
//   avg_out  : average including din (combinational, valid with en)
//   smp_out  : raw sample used by the pass and invert modes
module chan_avg #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] avg_out,
    output logic [DATA_W-1:0] smp_out
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [DATA_W-1:0] ring_q [DEPTH];
    logic [DATA_W-1:0] ring_d [DEPTH];
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [SUM_W-1:0]  sum_q, sum_d, sum_next;

    // The true sum never exceeds DEPTH*(2**DATA_W-1), so modular
    // arithmetic in SUM_W bits gives the exact value even though the
    // intermediate sum + din may wrap.
    always_comb begin
        sum_next = sum_q + SUM_W'(din) - SUM_W'(ring_q[wp_q]);
        avg_out  = sum_next[SUM_W-1:AVG_LOG2];
        smp_out  = din;
        ring_d   = ring_q;
        wp_d     = wp_q;
        sum_d    = sum_q;
        if (en) begin
            ring_d[wp_q] = din;
            sum_d        = sum_next;
            wp_d         = (wp_q == PTR_W'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= '0;
            end
            wp_q  <= '0;
            sum_q <= '0;
        end else begin
            ring_q <= ring_d;
            wp_q   <= wp_d;
            sum_q  <= sum_d;
        end
    end

endmodule

// File: rtl/adc_dac_sampler.sv
// Multi-channel sample engine between the ADC wrapper and a serial DAC
// encoder: conversion strobe, per-channel processing, pending storage and
// a round-robin scheduler driving the encoder's set/busy handshake.
//   clk, rst           : clock, synchronous active-high reset
//   mode               : 0 pass, 1 moving average, 2 hold, 3 invert
//   convst             : one-cycle conversion strobe
//   adc_valid/ch/data  : tagged ADC result
//   dac_set/busy       : encoder start pulse / busy handshake
//   dac_ch/data        : value being written, held until the next launch
//   overrun, hs_err    : sticky error flags
module adc_dac_sampler
    import adc_dac_pkg::*;
#(
    parameter int DATA_W        = 12,
    parameter int N_CH          = 2,
    parameter int CH_W          = 3,
    parameter int SAMPLE_FACTOR = 2000,
    parameter int AVG_LOG2      = 2,
    parameter int BUSY_TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    output logic              convst,
    input  logic              adc_valid,
    input  logic [CH_W-1:0]   adc_ch,
    input  logic [DATA_W-1:0] adc_data,
    output logic              dac_set,
    input  logic              dac_busy,
    output logic [CH_W-1:0]   dac_ch,
    output logic [DATA_W-1:0] dac_data,
    output logic              overrun,
    output logic              hs_err
);

    localparam int CNT_W = $clog2(SAMPLE_FACTOR);
    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic              dac_set_q, dac_set_d;
    logic [CH_W-1:0]   dac_ch_q, dac_ch_d;
    logic [DATA_W-1:0] dac_data_q, dac_data_d;
    logic              overrun_q, overrun_d;
    logic              hs_err_q, hs_err_d;
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [DATA_W-1:0] pend_data_q [N_CH];
    logic [DATA_W-1:0] pend_data_d [N_CH];

    logic [N_CH-1:0]   ch_en;
    logic [DATA_W-1:0] avg_vec [N_CH];
    logic [DATA_W-1:0] smp_vec [N_CH];
    logic              cap;
    logic [DATA_W-1:0] proc;
    logic              rr_found, launch;
    logic [CH_W-1:0]   rr_ch;
    logic [DATA_W-1:0] rr_data;

    // Free-running divider; the strobe is a decode of the terminal count.
    always_comb begin
        cnt_d = (cnt_q == CNT_W'(SAMPLE_FACTOR - 1)) ? '0 : cnt_q + 1'b1;
    end

    // Channel decode: out-of-range tags and hold mode touch no state.
    always_comb begin
        cap   = adc_valid && (32'(adc_ch) < N_CH) && (mode != MODE_HOLD);
        ch_en = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch_en[i] = cap && (adc_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        chan_avg #(
            .DATA_W   (DATA_W),
            .AVG_LOG2 (AVG_LOG2)
        ) u_avg (
            .clk     (clk),
            .rst     (rst),
            .en      (ch_en[g]),
            .din     (adc_data),
            .avg_out (avg_vec[g]),
            .smp_out (smp_vec[g])
        );
    end

    // Processed value of the incoming sample for its channel.
    always_comb begin
        proc = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (adc_ch == CH_W'(i)) begin
                case (mode)
                    MODE_AVG: proc = avg_vec[i];
                    MODE_INV: proc = ~smp_vec[i];
                    default:  proc = smp_vec[i];
                endcase
            end
        end
    end

    // Round-robin pick: first pending channel after the last one served.
    always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_ch    = '0;
        rr_data  = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (!rr_found && pend_q[i] && (idx == i)) begin
                    rr_found = 1'b1;
                    rr_ch    = CH_W'(i);
                    rr_data  = pend_data_q[i];
                end
            end
        end
    end

    // Scheduler: launch from IDLE, wait for busy to rise (bounded), then fall.
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        last_d     = last_q;
        dac_set_d  = 1'b0;
        dac_ch_d   = dac_ch_q;
        dac_data_d = dac_data_q;
        hs_err_d   = hs_err_q;
        launch     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    launch     = 1'b1;
                    dac_set_d  = 1'b1;
                    dac_ch_d   = rr_ch;
                    dac_data_d = rr_data;
                    last_d     = rr_ch;
                    tmo_d      = '0;
                    state_d    = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (dac_busy) begin
                    state_d = S_WAIT_LO;
                end else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
                    hs_err_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!dac_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pending slots: a launch clears its slot first so that a result
    // arriving for the same channel in that cycle re-arms it cleanly.
    always_comb begin
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        overrun_d   = overrun_q;
        for (int i = 0; i < N_CH; i++) begin
            if (launch && (rr_ch == CH_W'(i))) begin
                pend_d[i] = 1'b0;
            end
            if (ch_en[i]) begin
                if (pend_q[i] && !(launch && (rr_ch == CH_W'(i)))) begin
                    overrun_d = 1'b1;
                end
                pend_d[i]      = 1'b1;
                pend_data_d[i] = proc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            tmo_q      <= '0;
            last_q     <= CH_W'(N_CH - 1);
            dac_set_q  <= 1'b0;
            dac_ch_q   <= '0;
            dac_data_q <= '0;
            overrun_q  <= 1'b0;
            hs_err_q   <= 1'b0;
            pend_q     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                pend_data_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            last_q      <= last_d;
            dac_set_q   <= dac_set_d;
            dac_ch_q    <= dac_ch_d;
            dac_data_q  <= dac_data_d;
            overrun_q   <= overrun_d;
            hs_err_q    <= hs_err_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign convst   = (cnt_q == CNT_W'(SAMPLE_FACTOR - 1));
    assign dac_set  = dac_set_q;
    assign dac_ch   = dac_ch_q;
    assign dac_data = dac_data_q;
    assign overrun  = overrun_q;
    assign hs_err   = hs_err_q;

endmodule

// File: tb/tb_adc_dac_sampler.sv
// Self-checking bench for adc_dac_sampler with default parameters.
module tb_adc_dac_sampler;
    import adc_dac_pkg::*;

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [2:0]  ch;
        logic [11:0] data;
        bit          wr;
        logic [11:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        convst;
    logic        adc_valid;
    logic [2:0]  adc_ch;
    logic [11:0] adc_data;
    logic        dac_set;
    logic        dac_busy = 1'b0;
    logic [2:0]  dac_ch;
    logic [11:0] dac_data;
    logic        overrun;
    logic        hs_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t exp_item;
    int   busy_mode = 0;
    bit   bm_active = 1'b0;
    int   bm_d;
    int   bm_len;
    vec_t vecs [12];

    adc_dac_sampler dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .convst    (convst),
        .adc_valid (adc_valid),
        .adc_ch    (adc_ch),
        .adc_data  (adc_data),
        .dac_set   (dac_set),
        .dac_busy  (dac_busy),
        .dac_ch    (dac_ch),
        .dac_data  (dac_data),
        .overrun   (overrun),
        .hs_err    (hs_err)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Compare one value and keep the tallies
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one adc_valid pulse; returns #1 after the following edge
    task automatic applyStimulus(input logic [1:0] m, input logic [2:0] ch, input logic [11:0] d);
        mode      = m;
        adc_ch    = ch;
        adc_data  = d;
        adc_valid = 1'b1;
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
    endtask

    task automatic pushExp(input logic [2:0] ch, input logic [11:0] d);
        exp_t e;
        e.ch   = ch;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait until all expected writes happened and the encoder went idle
    task automatic waitIdle(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || bm_active) && k < budget) begin
            stepCycles(1);
            k++;
        end
        if (k >= budget) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: %0d writes still outstanding, expected 0", exp_q.size());
        end
        stepCycles(4);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        stepCycles(1);
        rst = 1'b0;
    endtask

    // Scoreboard: every dac_set pops the oldest expected write
    always @(negedge clk) begin
        if (dac_set === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_write: got ch=%0d data=0x%0h, expected no write", dac_ch, dac_data);
            end else begin
                exp_item = exp_q.pop_front();
                checkOutput("write_ch", 32'(dac_ch), 32'(exp_item.ch));
                checkOutput("write_data", 32'(dac_data), 32'(exp_item.data));
            end
        end
    end

    // Encoder model: 0 random timing, 1 busy for 200 cycles, 2 never busy
    always begin
        @(negedge clk);
        if (dac_set === 1'b1 && busy_mode != 2) begin
            bm_active = 1'b1;
            bm_d      = (busy_mode == 0) ? int'($urandom_range(3, 1)) : 1;
            bm_len    = (busy_mode == 0) ? int'($urandom_range(40, 3)) : 200;
            repeat (bm_d) @(posedge clk);
            #1 dac_busy = 1'b1;
            repeat (bm_len) @(posedge clk);
            #1 dac_busy = 1'b0;
            bm_active = 1'b0;
        end
    end

    // Hard stop in case something hangs
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s1, s2, h, k;

        vecs[0]  = '{MODE_AVG,  3'd0, 12'd100,  1'b1, 12'd25};
        vecs[1]  = '{MODE_AVG,  3'd0, 12'd200,  1'b1, 12'd75};
        vecs[2]  = '{MODE_AVG,  3'd0, 12'd300,  1'b1, 12'd150};
        vecs[3]  = '{MODE_AVG,  3'd0, 12'd400,  1'b1, 12'd250};
        vecs[4]  = '{MODE_AVG,  3'd0, 12'd400,  1'b1, 12'd325};
        vecs[5]  = '{MODE_INV,  3'd1, 12'h000,  1'b1, 12'hFFF};
        vecs[6]  = '{MODE_INV,  3'd0, 12'h0F0,  1'b1, 12'hF0F};
        vecs[7]  = '{MODE_PASS, 3'd0, 12'h123,  1'b1, 12'h123};
        vecs[8]  = '{MODE_HOLD, 3'd0, 12'h555,  1'b0, 12'h000};
        vecs[9]  = '{MODE_PASS, 3'd7, 12'h777,  1'b0, 12'h000};
        vecs[10] = '{MODE_AVG,  3'd0, 12'h000,  1'b1, 12'h0E8};
        vecs[11] = '{MODE_PASS, 3'd1, 12'hABC,  1'b1, 12'hABC};

        rst       = 1'b1;
        mode      = MODE_PASS;
        adc_valid = 1'b0;
        adc_ch    = '0;
        adc_data  = '0;
        stepCycles(2);
        checkOutput("reset_state", 32'({convst, dac_set, dac_ch, dac_data, overrun, hs_err}), 32'd0);
        rst = 1'b0;

        $display("[TB] convst timing after reset release");
        for (int c = 0; c <= 4000; c++) begin
            checkOutput($sformatf("convst_cycle%0d", c), 32'(convst), 32'((c == 1999) || (c == 3999)));
            stepCycles(1);
        end

        $display("[TB] pass mode and latency");
        pushExp(3'd0, 12'h123);
        applyStimulus(MODE_PASS, 3'd0, 12'h123);
        checkOutput("latency_t1", 32'(dac_set), 32'd0);
        stepCycles(1);
        checkOutput("latency_t2", 32'(dac_set), 32'd1);
        pushExp(3'd1, 12'hABC);
        applyStimulus(MODE_PASS, 3'd1, 12'hABC);
        waitIdle(300);

        $display("[TB] table vectors from reset");
        resetDut();
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                pushExp(vecs[i].ch, vecs[i].exp);
            end
            applyStimulus(vecs[i].mode, vecs[i].ch, vecs[i].data);
            waitIdle(300);
            checkOutput($sformatf("vec%0d_drained", i), 32'(exp_q.size()), 32'd0);
        end
        checkOutput("table_flags", 32'({overrun, hs_err}), 32'd0);

        $display("[TB] overrun while encoder busy");
        busy_mode = 1;
        pushExp(3'd0, 12'h100);
        applyStimulus(MODE_PASS, 3'd0, 12'h100);
        stepCycles(10);
        applyStimulus(MODE_PASS, 3'd0, 12'h200);
        stepCycles(3);
        applyStimulus(MODE_PASS, 3'd0, 12'h300);
        stepCycles(3);
        pushExp(3'd0, 12'h400);
        applyStimulus(MODE_PASS, 3'd0, 12'h400);
        checkOutput("overrun_set", 32'(overrun), 32'd1);
        waitIdle(700);
        checkOutput("overrun_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("overrun_no_hs_err", 32'(hs_err), 32'd0);

        $display("[TB] busy never rises");
        busy_mode = 2;
        pushExp(3'd0, 12'h111);
        pushExp(3'd1, 12'h222);
        applyStimulus(MODE_PASS, 3'd0, 12'h111);
        applyStimulus(MODE_PASS, 3'd1, 12'h222);
        s1 = -1;
        s2 = -1;
        h  = -1;
        for (int c = 0; c < 60; c++) begin
            if (dac_set === 1'b1) begin
                if (s1 < 0) s1 = c;
                else if (s2 < 0) s2 = c;
            end
            if (hs_err === 1'b1 && h < 0) h = c;
            stepCycles(1);
        end
        checkOutput("timeout_launch", 32'(s1), 32'd0);
        checkOutput("hs_err_delay", 32'(h - s1), 32'd15);
        checkOutput("next_channel_served", 32'(s2 - s1), 32'd16);
        checkOutput("timeout_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] reset during transfer");
        busy_mode = 1;
        pushExp(3'd1, 12'h3C3);
        applyStimulus(MODE_PASS, 3'd1, 12'h3C3);
        k = 0;
        while (dac_busy !== 1'b1 && k < 20) begin
            stepCycles(1);
            k++;
        end
        checkOutput("busy_seen", 32'(dac_busy), 32'd1);
        stepCycles(1);
        checkOutput("flags_before_rst", 32'({overrun, hs_err}), 32'd3);
        rst = 1'b1;
        stepCycles(1);
        checkOutput("rst_mid_transfer", 32'({convst, dac_set, dac_ch, dac_data, overrun, hs_err}), 32'd0);
        rst = 1'b0;
        stepCycles(3);
        checkOutput("rst_final_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
